// File: rtl/atomicity_monitor_mr.sv
// Program-counter atomicity monitor for one protected code region with up to four entry points.
// Any illegal entry, exit, internal jump or in-region interrupt holds the CPU in reset.
module atomicity_monitor_mr #(
  parameter logic [15:0] SMEM_BASE     = 16'hA000,
  parameter logic [15:0] SMEM_SIZE     = 16'h4000,
  parameter int unsigned NUM_ENTRY     = 3,
  parameter logic [15:0] ENTRY0        = 16'hA000,
  parameter logic [15:0] ENTRY1        = 16'hA108,
  parameter logic [15:0] ENTRY2        = 16'hA18A,
  parameter logic [15:0] ENTRY3        = 16'hA000,
  parameter bit          IRQ_CHECK     = 1'b1,
  parameter logic [7:0]  KILL_HOLD     = 8'd1,
  parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic        pc_en,
  input  logic        irq,
  output logic        reset,
  output logic [2:0]  viol_cause,
  output logic [7:0]  viol_cnt
);

  localparam logic [15:0] LastAddr = 16'(SMEM_BASE + SMEM_SIZE - 16'd2);

  localparam logic [2:0] CauseNone     = 3'd0;
  localparam logic [2:0] CauseEntry    = 3'd1;
  localparam logic [2:0] CauseExit     = 3'd2;
  localparam logic [2:0] CauseInternal = 3'd3;
  localparam logic [2:0] CauseIrq      = 3'd4;

  typedef enum logic [2:0] {StNotRc, StFstRc, StMidRc, StLastRc, StKill} state_e;

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] cause_q, cause_d;
  logic [7:0] cnt_q, cnt_d;
  logic       reset_q;

  logic       is_first, is_last, is_mid, is_out;
  logic       kill;
  logic [2:0] kill_cause;

  // FIRST wins over MID; disabled entry slots never match.
  always_comb begin
    is_first = (pc == ENTRY0) ||
               ((NUM_ENTRY > 1) && (pc == ENTRY1)) ||
               ((NUM_ENTRY > 2) && (pc == ENTRY2)) ||
               ((NUM_ENTRY > 3) && (pc == ENTRY3));
    is_last  = (pc == LastAddr);
    is_mid   = (pc >= SMEM_BASE) && (pc < LastAddr) && !is_first;
    is_out   = (pc < SMEM_BASE) || (pc > LastAddr);
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cause_d    = cause_q;
    cnt_d      = cnt_q;
    kill       = 1'b0;
    kill_cause = CauseNone;

    if (state_q == StKill) begin
      if (hold_q != 8'd0) begin
        hold_d = hold_q - 8'd1;
      end else if (pc_en && (pc == RESET_HANDLER)) begin
        state_d = StNotRc;
      end
    end else if (IRQ_CHECK && irq && (state_q != StNotRc)) begin
      kill       = 1'b1;
      kill_cause = CauseIrq;
    end else if (pc_en) begin
      case (state_q)
        StNotRc: begin
          if (is_first) begin
            state_d = StFstRc;
          end else if (!is_out) begin
            kill       = 1'b1;
            kill_cause = CauseEntry;
          end
        end
        StFstRc: begin
          if (is_mid) begin
            state_d = StMidRc;
          end else if (is_out) begin
            kill       = 1'b1;
            kill_cause = CauseExit;
          end else if (is_last) begin
            kill       = 1'b1;
            kill_cause = CauseInternal;
          end
        end
        StMidRc: begin
          if (is_last) begin
            state_d = StLastRc;
          end else if (is_out) begin
            kill       = 1'b1;
            kill_cause = CauseExit;
          end else if (is_first) begin
            kill       = 1'b1;
            kill_cause = CauseInternal;
          end
        end
        StLastRc: begin
          if (is_out) begin
            state_d = StNotRc;
          end else if (!is_last) begin
            kill       = 1'b1;
            kill_cause = CauseInternal;
          end
        end
        default: ;
      endcase
    end

    if (kill) begin
      state_d = StKill;
      hold_d  = KILL_HOLD - 8'd1;
      cause_d = kill_cause;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StKill;
      hold_q  <= 8'd0;
      cause_q <= CauseNone;
      cnt_q   <= 8'd0;
      reset_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      reset_q <= (state_d == StKill);
    end
  end

  assign reset      = reset_q;
  assign viol_cause = cause_q;
  assign viol_cnt   = cnt_q;

endmodule

// File: tb/tb_atomicity_monitor_mr.sv
// Bench for atomicity_monitor_mr: three instances (default, IRQ_CHECK=0, KILL_HOLD=4) share
// one stimulus stream and are checked against a transition-rule reference model.
module tb_atomicity_monitor_mr;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        pc_en = 1'b0;
  logic        irq = 1'b0;

  logic [2:0]       rst_o;
  logic [2:0][2:0]  cause_o;
  logic [2:0][7:0]  cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  atomicity_monitor_mr u_dut0 (
    .clk(clk), .reset_n(reset_n), .pc(pc), .pc_en(pc_en), .irq(irq),
    .reset(rst_o[0]), .viol_cause(cause_o[0]), .viol_cnt(cnt_o[0])
  );
  atomicity_monitor_mr #(.IRQ_CHECK(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .pc(pc), .pc_en(pc_en), .irq(irq),
    .reset(rst_o[1]), .viol_cause(cause_o[1]), .viol_cnt(cnt_o[1])
  );
  atomicity_monitor_mr #(.KILL_HOLD(8'd4)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .pc(pc), .pc_en(pc_en), .irq(irq),
    .reset(rst_o[2]), .viol_cause(cause_o[2]), .viol_cnt(cnt_o[2])
  );

  // Reference model: where the program last legally was, plus kill bookkeeping.
  typedef enum int {Out = 0, First = 1, Mid = 2, Last = 3} cls_e;
  bit   m_kill  [3];
  cls_e m_where [3];
  int   m_hold  [3];
  int   m_cause [3];
  int   m_cnt   [3];

  function automatic cls_e classify(input logic [15:0] p);
    if (p == 16'hA000 || p == 16'hA108 || p == 16'hA18A) return First;
    if (p == 16'hDFFE) return Last;
    if (p >= 16'hA000 && p < 16'hDFFE) return Mid;
    return Out;
  endfunction

  // Legal flow is Out -> First -> Mid -> Last -> Out, with repeats allowed.
  function automatic bit legal(input cls_e from, input cls_e to);
    return (to == from) || (int'(to) == (int'(from) + 1) % 4);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_kill[c] = 1'b1; m_hold[c] = 0; m_where[c] = Out; m_cause[c] = 0; m_cnt[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < 3; c++) begin
      if (m_kill[c]) begin
        if (m_hold[c] > 0) m_hold[c]--;
        else if (pc_en && pc == 16'hFFFE) begin m_kill[c] = 1'b0; m_where[c] = Out; end
      end else begin
        bit   v  = 1'b0;
        int   cs = 0;
        cls_e cl;
        if (c != 1 && irq && m_where[c] != Out) begin
          v = 1'b1; cs = 4;
        end else if (pc_en) begin
          cl = classify(pc);
          if (legal(m_where[c], cl)) m_where[c] = cl;
          else begin
            v  = 1'b1;
            cs = (m_where[c] == Out) ? 1 : (cl == Out) ? 2 : 3;
          end
        end
        if (v) begin
          m_kill[c]  = 1'b1;
          m_hold[c]  = ((c == 2) ? 4 : 1) - 1;
          m_cause[c] = cs;
          m_cnt[c]   = (m_cnt[c] < 255) ? m_cnt[c] + 1 : 255;
        end
      end
    end
  endtask

  task automatic tick(input logic [15:0] p, input logic e, input logic i);
    pc = p; pc_en = e; irq = i;
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic release_kill();
    repeat (4) tick(16'hFFFE, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    model_reset();
    #2;
    n_vec++;
    if ({rst_o, cause_o, cnt_o} !== {3'b111, 9'd0, 24'd0}) begin
      n_err++;
      $display("FAIL reset_state: rst=%b cause=%h cnt=%h, want 111 000 000000", rst_o, cause_o,
               cnt_o);
    end
    #9 reset_n = 1'b1;
    tick(16'h4000, 1'b1, 1'b0);
    n_vec++;
    if (rst_o !== 3'b111) begin
      n_err++; $display("FAIL reset_hold_non_handler: rst=%b, want 111", rst_o);
    end
    tick(16'hFFFE, 1'b1, 1'b0);
    n_vec++;
    if (rst_o !== 3'b000) begin
      n_err++; $display("FAIL reset_release: rst=%b, want 000", rst_o);
    end
  endtask

  task automatic test_legal_run();
    logic [15:0] seq [6] = '{16'h4000, 16'hA000, 16'hA002, 16'hA004, 16'hDFFE, 16'h4400};
    release_kill();
    foreach (seq[k]) begin
      tick(seq[k], 1'b1, 1'b0);
      n_vec++;
      if (rst_o !== 3'b000) begin
        n_err++; $display("FAIL legal_run pc=%h: rst=%b, want 000", seq[k], rst_o);
      end
    end
    n_vec++;
    if (cnt_o !== 24'd0) begin
      n_err++; $display("FAIL legal_run_cnt: cnt=%h, want 000000", cnt_o);
    end
  endtask

  task automatic test_illegal_entry();
    tick(16'h4000, 1'b1, 1'b0);
    tick(16'hA010, 1'b1, 1'b0);
    n_vec++;
    if ({rst_o, cause_o, cnt_o} !== {3'b111, {3{3'd1}}, {3{8'd1}}}) begin
      n_err++;
      $display("FAIL illegal_entry: rst=%b cause=%h cnt=%h, want 111 cause1 cnt1", rst_o, cause_o,
               cnt_o);
    end
    for (int p = 16'h4000; p <= 16'h4010; p += 2) begin
      tick(16'(p), 1'b1, 1'b0);
      n_vec++;
      if (rst_o !== 3'b111) begin
        n_err++; $display("FAIL entry_kill_hold pc=%h: rst=%b, want 111", p, rst_o);
      end
    end
    tick(16'hFFFE, 1'b1, 1'b0);
    n_vec++;
    if (rst_o !== 3'b000) begin
      n_err++; $display("FAIL entry_release: rst=%b, want 000", rst_o);
    end
  endtask

  task automatic test_illegal_exit();
    tick(16'hA108, 1'b1, 1'b0); tick(16'hA10A, 1'b1, 1'b0); tick(16'h4000, 1'b1, 1'b0);
    n_vec++;
    if ({rst_o, cause_o, cnt_o} !== {3'b111, {3{3'd2}}, {3{8'd2}}}) begin
      n_err++;
      $display("FAIL illegal_exit: rst=%b cause=%h cnt=%h, want 111 cause2 cnt2", rst_o, cause_o,
               cnt_o);
    end
    release_kill();
    tick(16'hA108, 1'b1, 1'b0); tick(16'hA10A, 1'b1, 1'b0); tick(16'hA18A, 1'b1, 1'b0);
    n_vec++;
    if ({rst_o, cause_o, cnt_o} !== {3'b111, {3{3'd3}}, {3{8'd3}}}) begin
      n_err++;
      $display("FAIL mid_to_entry: rst=%b cause=%h cnt=%h, want 111 cause3 cnt3", rst_o, cause_o,
               cnt_o);
    end
    release_kill();
    tick(16'hA108, 1'b1, 1'b0); tick(16'hA10A, 1'b1, 1'b0); tick(16'hDFFE, 1'b1, 1'b0);
    tick(16'hA100, 1'b1, 1'b0);
    n_vec++;
    if ({rst_o, cause_o, cnt_o} !== {3'b111, {3{3'd3}}, {3{8'd4}}}) begin
      n_err++;
      $display("FAIL last_to_mid: rst=%b cause=%h cnt=%h, want 111 cause3 cnt4", rst_o, cause_o,
               cnt_o);
    end
    release_kill();
  endtask

  task automatic test_irq();
    tick(16'hA108, 1'b1, 1'b0); tick(16'hA10A, 1'b1, 1'b0);
    tick(16'hA10C, 1'b0, 1'b1);
    n_vec++;
    if (rst_o !== 3'b101 || cause_o[0] !== 3'd4 || cause_o[2] !== 3'd4) begin
      n_err++;
      $display("FAIL irq_in_region: rst=%b cause=%h, want rst 101 cause4 on dut0/dut2", rst_o,
               cause_o);
    end
    tick(16'hDFFE, 1'b1, 1'b0); tick(16'h4400, 1'b1, 1'b0);
    n_vec++;
    if (rst_o[1] !== 1'b0 || cnt_o[1] !== 8'd4) begin
      n_err++;
      $display("FAIL irq_ignored: rst=%b cnt=%0d, want 0 4", rst_o[1], cnt_o[1]);
    end
    release_kill();
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if ({rst_o[c], cause_o[c], cnt_o[c]} !== {m_kill[c], 3'(m_cause[c]), 8'(m_cnt[c])}) begin
        n_err++;
        $display("FAIL irq_model dut%0d: got %b/%0d/%0d, want %b/%0d/%0d", c, rst_o[c],
                 cause_o[c], cnt_o[c], m_kill[c], m_cause[c], m_cnt[c]);
      end
    end
  endtask

  task automatic test_pc_en_hold();
    tick(16'hA010, 1'b0, 1'b0);
    tick(16'hDFFE, 1'b0, 1'b0);
    n_vec++;
    if (rst_o !== 3'b000) begin
      n_err++; $display("FAIL pc_en_gate: rst=%b, want 000", rst_o);
    end
    tick(16'hA010, 1'b1, 1'b0);
    n_vec++;
    if (rst_o !== 3'b111) begin
      n_err++; $display("FAIL hold_entry: rst=%b, want 111", rst_o);
    end
    for (int k = 1; k <= 4; k++) begin
      tick(16'hFFFE, 1'b1, 1'b0);
      n_vec++;
      if (rst_o[2] !== (k < 4) || rst_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL kill_hold cycle%0d: rst=%b, want dut2=%0b dut0=0", k, rst_o, k < 4);
      end
    end
  endtask

  task automatic test_async_reset();
    tick(16'hA108, 1'b1, 1'b0); tick(16'hA10A, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({rst_o, cause_o, cnt_o} !== {3'b111, 9'd0, 24'd0}) begin
      n_err++;
      $display("FAIL async_reset: rst=%b cause=%h cnt=%h, want 111 000 000000", rst_o, cause_o,
               cnt_o);
    end
    #2 reset_n = 1'b1;
    tick(16'hFFFE, 1'b1, 1'b0);
    n_vec++;
    if (rst_o !== 3'b000) begin
      n_err++; $display("FAIL async_release: rst=%b, want 000", rst_o);
    end
  endtask

  task automatic test_saturate();
    repeat (260) begin
      tick(16'hA010, 1'b1, 1'b0);
      release_kill();
    end
    n_vec++;
    if (cnt_o !== {3{8'hFF}}) begin
      n_err++; $display("FAIL cnt_saturate: cnt=%h, want ffffff", cnt_o);
    end
  endtask

  task automatic test_random();
    logic [15:0] entries [3] = '{16'hA000, 16'hA108, 16'hA18A};
    logic [15:0] edges   [4] = '{16'h9FFE, 16'hE000, 16'h4000, 16'hDFFF};
    logic [15:0] p;
    int          r;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      p = 16'hFFFE;
      else if (r < 38) p = entries[$urandom_range(0, 2)];
      else if (r < 48) p = 16'hDFFE;
      else if (r < 75) p = 16'(16'hA000 + 2 * $urandom_range(0, 8190));
      else if (r < 85) p = 16'($urandom_range(0, 65535));
      else             p = edges[$urandom_range(0, 3)];
      tick(p, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) == 0));
      for (int c = 0; c < 3; c++) begin
        n_vec++;
        if ({rst_o[c], cause_o[c], cnt_o[c]} !== {m_kill[c], 3'(m_cause[c]), 8'(m_cnt[c])}) begin
          n_err++;
          $display("FAIL random n=%0d dut%0d pc=%h: got %b/%0d/%0d, want %b/%0d/%0d", n, c, pc,
                   rst_o[c], cause_o[c], cnt_o[c], m_kill[c], m_cause[c], m_cnt[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal_run();
    test_illegal_entry();
    test_illegal_exit();
    test_irq();
    test_pc_en_hold();
    test_async_reset();
    test_saturate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
